// File: rtl/btn_debounce.sv
// Push-button conditioner: per-button two-flop synchronizer, stability-counter
// debounce, and single-cycle press / release / long-press pulses.
module btn_debounce #(
    parameter int NUM_BTN           = 5,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 100000000
) (
    input  logic               clk100m,
    input  logic               rstn,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HD_W-1:0] HD_MAX  = HD_W'(LONG_PRESS_CYCLES);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(LONG_PRESS_CYCLES - 1);

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        logic            r_sync1;
        logic            r_sync2;
        logic            r_level;
        logic            r_press;
        logic            r_release;
        logic            r_long;
        logic [DB_W-1:0] r_db_cnt;
        logic [HD_W-1:0] r_hold_cnt;

        logic            w_differ;
        logic            w_db_done;
        logic            w_hold_sat;

        assign w_differ   = (r_sync2 != r_level);
        assign w_db_done  = w_differ && (r_db_cnt == DB_LAST);
        assign w_hold_sat = (r_hold_cnt == HD_MAX);

        always_ff @(posedge clk100m) begin
            if (!rstn) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= btn_raw[b];
                r_sync2 <= r_sync1;
            end
        end

        // Any sample that agrees with the accepted level restarts the count,
        // so only an uninterrupted run of DEBOUNCE_CYCLES changes are accepted.
        always_ff @(posedge clk100m) begin
            if (!rstn) begin
                r_level   <= 1'b0;
                r_db_cnt  <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                if (!w_differ) begin
                    r_db_cnt <= '0;
                end else if (w_db_done) begin
                    r_level   <= r_sync2;
                    r_db_cnt  <= '0;
                    r_press   <= r_sync2;
                    r_release <= ~r_sync2;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

        // Saturating hold counter; the long pulse is tied to the single
        // transition into saturation so it cannot repeat within one press.
        always_ff @(posedge clk100m) begin
            if (!rstn) begin
                r_hold_cnt <= '0;
                r_long     <= 1'b0;
            end else begin
                r_long <= r_level && (r_hold_cnt == HD_LAST);
                if (!r_level) begin
                    r_hold_cnt <= '0;
                end else if (!w_hold_sat) begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end
            end
        end

        assign btn_level[b]   = r_level;
        assign btn_press[b]   = r_press;
        assign btn_release[b] = r_release;
        assign btn_long[b]    = r_long;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed button waveforms, an every-cycle comparison
// against a sample-history model, and hand-computed pulse timings.
module tb_btn_debounce;

    localparam int NB = 2;
    localparam int DB = 4;
    localparam int LP = 16;

    logic          clk100m = 1'b0;
    logic          rstn;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;

    btn_debounce #(
        .NUM_BTN          (NB),
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP)
    ) u_dut (
        .clk100m    (clk100m),
        .rstn       (rstn),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk100m = ~clk100m;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model state: raw samples and synchronized samples since the last reset.
    logic [NB-1:0] rq[$];
    logic [NB-1:0] sq[$];
    int            chg_idx[NB];
    int            rise_cyc[NB];
    logic [NB-1:0] m_level, m_press, m_release, m_long;
    bit            m_valid = 0;

    // DUT pulse bookkeeping for the directed checks.
    int press_cnt[NB], release_cnt[NB], long_cnt[NB];
    int press_at[NB], release_at[NB], long_at[NB];

    always begin
        @(posedge clk100m);
        cyc++;
        if (!rstn) begin
            rq.delete();
            sq.delete();
            m_level = '0; m_press = '0; m_release = '0; m_long = '0;
            for (int b = 0; b < NB; b++) begin
                chg_idx[b]  = -1;
                rise_cyc[b] = 0;
            end
            m_valid = 1;
        end else if (m_valid) begin
            logic [NB-1:0] d;
            rq.push_back(btn_raw);
            d = (rq.size() >= 3) ? rq[rq.size()-3] : '0;
            sq.push_back(d);
            m_press = '0; m_release = '0; m_long = '0;
            for (int b = 0; b < NB; b++) begin
                int  n;
                bit  all_diff;
                m_long[b] = m_level[b] && (cyc - rise_cyc[b] == LP);
                // Accept a new level once the last DB samples after the
                // previous change all disagree with the current level.
                n = sq.size();
                all_diff = (n - DB > chg_idx[b]);
                for (int k = 0; k < DB && all_diff; k++)
                    if (sq[n-1-k][b] == m_level[b]) all_diff = 0;
                if (all_diff) begin
                    m_level[b]   = ~m_level[b];
                    m_press[b]   = m_level[b];
                    m_release[b] = ~m_level[b];
                    chg_idx[b]   = n - 1;
                    if (m_level[b]) rise_cyc[b] = cyc;
                end
            end
        end
        #1;
        if (m_valid) begin
            check("level",   btn_level,   m_level);
            check("press",   btn_press,   m_press);
            check("release", btn_release, m_release);
            check("long",    btn_long,    m_long);
            for (int b = 0; b < NB; b++) begin
                if (btn_press[b] === 1'b1)   begin press_cnt[b]++;   press_at[b]   = cyc; end
                if (btn_release[b] === 1'b1) begin release_cnt[b]++; release_at[b] = cyc; end
                if (btn_long[b] === 1'b1)    begin long_cnt[b]++;    long_at[b]    = cyc; end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk100m);
    endtask

    task automatic clear_stats();
        for (int b = 0; b < NB; b++) begin
            press_cnt[b] = 0; release_cnt[b] = 0; long_cnt[b] = 0;
            press_at[b] = -1; release_at[b] = -1; long_at[b] = -1;
        end
    endtask

    bit bounce[10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

    initial begin
        int start;
        int fall;
        rstn    = 1'b0;
        btn_raw = 2'b11;
        clear_stats();

        // Reset with both buttons held, then release reset.
        cycles(3);
        check("rst_level", btn_level, 0);
        check("rst_pulses", {btn_press, btn_release, btn_long}, 0);
        rstn  = 1'b1;
        start = cyc + 1;
        cycles(8);
        check("rst_press_cnt0", press_cnt[0], 1);
        check("rst_press_cnt1", press_cnt[1], 1);
        check("rst_press_lat", press_at[0] - start + 1, 6);
        check("rst_press_same", press_at[1], press_at[0]);
        btn_raw = 2'b00;
        cycles(12);

        // Clean press held 30 cycles.
        clear_stats();
        btn_raw[0] = 1'b1;
        start = cyc + 1;
        cycles(30);
        btn_raw[0] = 1'b0;
        fall = cyc + 1;
        cycles(12);
        check("clean_press_cnt", press_cnt[0], 1);
        check("clean_press_lat", press_at[0] - start + 1, 6);
        check("clean_long_cnt", long_cnt[0], 1);
        check("clean_long_lat", long_at[0] - press_at[0], 16);
        check("clean_rel_cnt", release_cnt[0], 1);
        check("clean_rel_lat", release_at[0] - fall + 1, 6);
        check("clean_btn1_quiet", press_cnt[1] + release_cnt[1] + long_cnt[1], 0);

        // Bouncing press.
        clear_stats();
        start = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = bounce[i];
            cycles(1);
        end
        btn_raw[0] = 1'b1;
        cycles(25);
        check("bounce_press_cnt", press_cnt[0], 1);
        check("bounce_press_lat", press_at[0] - start + 1, 11);
        btn_raw[0] = 1'b0;
        cycles(12);

        // Glitch one cycle shorter than the debounce window, then exactly as long.
        clear_stats();
        btn_raw[1] = 1'b1;
        cycles(3);
        btn_raw[1] = 1'b0;
        cycles(10);
        check("glitch_press_cnt", press_cnt[1], 0);
        check("glitch_level", btn_level[1], 0);
        btn_raw[1] = 1'b1;
        start = cyc + 1;
        cycles(4);
        btn_raw[1] = 1'b0;
        cycles(12);
        check("minpulse_press_cnt", press_cnt[1], 1);
        check("minpulse_press_lat", press_at[1] - start + 1, 6);
        check("minpulse_rel_cnt", release_cnt[1], 1);
        check("minpulse_no_long", long_cnt[1], 0);

        // Short press: released before the hold counter saturates.
        clear_stats();
        btn_raw[0] = 1'b1;
        start = cyc + 1;
        cycles(14);
        btn_raw[0] = 1'b0;
        cycles(30);
        check("short_press_cnt", press_cnt[0], 1);
        check("short_rel_cnt", release_cnt[0], 1);
        check("short_rel_lat", release_at[0] - start + 1, 20);
        check("short_no_long", long_cnt[0], 0);

        // Reset pulse 10 edges after the press, button held throughout.
        clear_stats();
        btn_raw[0] = 1'b1;
        start = cyc + 1;
        cycles(15);
        rstn = 1'b0;
        cycles(1);
        check("midrst_level", btn_level, 0);
        rstn  = 1'b1;
        start = cyc + 1;
        cycles(20);
        check("midrst_press_cnt", press_cnt[0], 2);
        check("midrst_press_lat", press_at[0] - start + 1, 6);
        check("midrst_no_rel", release_cnt[0], 0);
        check("midrst_no_long", long_cnt[0], 0);
        btn_raw[0] = 1'b0;
        cycles(12);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Input conditioner for the board push-buttons, and the input-side counterpart to the LED drivers. It synchronizes each raw button into the clk100m domain and debounces it with a per-button stability counter. From the debounced level it produces single-cycle press, release and long-press pulses. Downstream logic consumes these pulses instead of touching the raw pins.

## Interface
- NUM_BTN, 5, number of independent buttons (≥1)
- DEBOUNCE_CYCLES, 1000000, consecutive cycles of a changed synchronized value required to accept it (10 ms at 100 MHz; ≥1)
- LONG_PRESS_CYCLES, 100000000, cycles the debounced level must stay high before btn_long fires (1 s; ≥1)
- clk100m  input  1  100 MHz system clock; all logic on its rising edge
- rstn  input  1  synchronous, active-low reset
- btn_raw  input  NUM_BTN  asynchronous, bouncy button pins, active-high
- btn_level  output  NUM_BTN  debounced level, registered
- btn_press  output  NUM_BTN  one-cycle pulse on debounced 0→1
- btn_release  output  NUM_BTN  one-cycle pulse on debounced 1→0
- btn_long  output  NUM_BTN  one-cycle pulse after LONG_PRESS_CYCLES of continuous high level

## Operation
- Per button, fully independent. No cross-button interaction.
- Synchronizer: two flops, sync1 ← btn_raw, sync2 ← sync1. Both reset to 0.
- Debounce counter db_cnt, width $clog2(DEBOUNCE_CYCLES+1):
  - sync2 == btn_level → db_cnt ← 0.
  - sync2 != btn_level and db_cnt == DEBOUNCE_CYCLES-1 → btn_level ← sync2, db_cnt ← 0.
  - Otherwise → db_cnt ← db_cnt+1.
- Any single-cycle return of sync2 to btn_level restarts the count from 0. A glitch shorter than DEBOUNCE_CYCLES never changes btn_level.
- btn_press / btn_release are registered and asserted in the same cycle btn_level changes. They are high for exactly one cycle.
- Hold counter hold_cnt, width $clog2(LONG_PRESS_CYCLES+1):
  - Cleared whenever btn_level is 0.
  - While btn_level is 1 and hold_cnt < LONG_PRESS_CYCLES, increments each cycle.
  - Saturates at LONG_PRESS_CYCLES.
- btn_long is asserted for one cycle on the edge where hold_cnt goes LONG_PRESS_CYCLES-1 → LONG_PRESS_CYCLES. It fires at most once per press, with no auto-repeat.
- Release before saturation: btn_release pulses and btn_long never fires for that press.
- Release after btn_long: btn_release pulses normally.

## Timing
- Reset: sync1, sync2, btn_level, db_cnt, hold_cnt, btn_press, btn_release, btn_long all 0 on the first edge with rstn low. Reset dominates all other updates.
- Press latency: let edge 1 be the first edge that samples btn_raw high, with raw held stable. Then:
  - sync2 is high after edge 2.
  - btn_level and btn_press go high after edge DEBOUNCE_CYCLES+2.
- Release latency is identical: DEBOUNCE_CYCLES+2 edges.
- btn_long: high after the LONG_PRESS_CYCLES-th edge following the edge that raised btn_level.
- Mid-operation reset: everything clears. A button held through reset is treated as a new press after release of rstn, with btn_press after DEBOUNCE_CYCLES+2 edges.
- btn_press and btn_release are never high in the same cycle for the same button. Minimum spacing between them is DEBOUNCE_CYCLES cycles.

## Test plan
Use NUM_BTN=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16 unless noted.

- **Reset:** hold rstn=0 with btn_raw=2'b11 for 3 cycles → all outputs 0. Release rstn → btn_level=2'b11 and btn_press=2'b11 for one cycle, 6 edges later.
- **Clean press/release:** btn_raw[0] 0→1 held 30 cycles, then 0 →
  - btn_press[0] one cycle at edge 6.
  - btn_long[0] one cycle 16 edges after that.
  - btn_release[0] one cycle 6 edges after the fall.
  - btn[1] outputs stay 0 throughout.
- **Bounce:** btn_raw[0] toggles 1,0,1,1,0,1,1,1,1,1… → btn_level[0] rises only after 4 consecutive high synchronized samples. Exactly one btn_press[0].
- **Short glitch:** btn_raw[1] high for 3 cycles, then low → no btn_press[1], btn_level[1] stays 0, db_cnt returns to 0.
- **Short press:** btn_raw[0] held high 14 cycles → btn_press and btn_release each pulse once, btn_long never fires.
- **Reset mid-hold:** assert rstn=0 for 1 cycle 10 edges after btn_press[0], with raw held high → outputs clear. btn_press[0] again 6 edges after rstn=1. No btn_release[0] and no btn_long[0] from the aborted press.
